// File: rtl/register_array_pq.sv
// rtl/register_array_pq.sv - register-array priority queue of (key, value) pairs
// Sorted cells with per-cell valid bits; equal keys drain in arrival order.
module register_array_pq #(
  parameter int DEPTH     = 8,
  parameter int KEY_WIDTH = 16,
  parameter int VAL_WIDTH = 16,
  parameter int MAX_FIRST = 1,
  parameter int AF_THRESH = DEPTH - 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 i_CLK,
  input  logic                 i_RSTn,
  input  logic                 i_flush,
  input  logic                 i_push_valid,
  output logic                 o_push_ready,
  input  logic [KEY_WIDTH-1:0] i_push_key,
  input  logic [VAL_WIDTH-1:0] i_push_val,
  output logic                 o_pop_valid,
  input  logic                 i_pop_ready,
  output logic [KEY_WIDTH-1:0] o_top_key,
  output logic [VAL_WIDTH-1:0] o_top_val,
  output logic [CW-1:0]        o_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full
);

  if (DEPTH < 2 || AF_THRESH > DEPTH) begin : g_param_check
    $error("register_array_pq: DEPTH must be >= 2 and AF_THRESH <= DEPTH");
  end

  logic [KEY_WIDTH-1:0] key_q [DEPTH];
  logic [KEY_WIDTH-1:0] key_d [DEPTH];
  logic [VAL_WIDTH-1:0] val_q [DEPTH];
  logic [VAL_WIDTH-1:0] val_d [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [CW-1:0]        count_q, count_d;

  logic [KEY_WIDTH-1:0] ext_key [DEPTH+1];
  logic [VAL_WIDTH-1:0] ext_val [DEPTH+1];
  logic [DEPTH:0]       ext_vld;
  logic [KEY_WIDTH-1:0] s_key [DEPTH];
  logic [VAL_WIDTH-1:0] s_val [DEPTH];
  logic [DEPTH-1:0]     s_vld;
  logic [KEY_WIDTH-1:0] up_key [DEPTH];
  logic [VAL_WIDTH-1:0] up_val [DEPTH];
  logic [DEPTH-1:0]     up_vld;
  logic [CW-1:0]        ins_idx;
  logic                 pop, push, precedes;

  assign o_empty       = (count_q == '0);
  assign o_full        = (count_q == CW'(DEPTH));
  assign o_almost_full = (count_q >= CW'(AF_THRESH));
  assign o_pop_valid   = !o_empty;
  assign o_push_ready  = !o_full | i_pop_ready;
  assign o_top_key     = key_q[0];
  assign o_top_val     = val_q[0];
  assign o_count       = count_q;

  assign pop  = o_pop_valid & i_pop_ready;
  assign push = i_push_valid & o_push_ready;

  always_comb begin
    ins_idx  = '0;
    precedes = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ext_key[i] = key_q[i];
      ext_val[i] = val_q[i];
      ext_vld[i] = vld_q[i];
    end
    ext_key[DEPTH] = '0;
    ext_val[DEPTH] = '0;
    ext_vld[DEPTH] = 1'b0;

    // Shifted view: what the array looks like after the pop (if any) is applied
    for (int i = 0; i < DEPTH; i++) begin
      s_key[i] = pop ? ext_key[i+1] : ext_key[i];
      s_val[i] = pop ? ext_val[i+1] : ext_val[i];
      s_vld[i] = pop ? ext_vld[i+1] : ext_vld[i];
    end

    up_key[0] = '0;
    up_val[0] = '0;
    up_vld[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      up_key[i] = s_key[i-1];
      up_val[i] = s_val[i-1];
      up_vld[i] = s_vld[i-1];
    end

    // ">=" / "<=" keeps existing equal keys ahead of the newcomer (FIFO ties)
    for (int i = 0; i < DEPTH; i++) begin
      precedes = (MAX_FIRST != 0) ? (s_key[i] >= i_push_key) : (s_key[i] <= i_push_key);
      if (s_vld[i] && precedes) ins_idx = ins_idx + CW'(1);
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (!push || CW'(i) < ins_idx) begin
        key_d[i] = s_key[i];
        val_d[i] = s_val[i];
        vld_d[i] = s_vld[i];
      end else if (CW'(i) == ins_idx) begin
        key_d[i] = i_push_key;
        val_d[i] = i_push_val;
        vld_d[i] = 1'b1;
      end else begin
        key_d[i] = up_key[i];
        val_d[i] = up_val[i];
        vld_d[i] = up_vld[i];
      end
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_d[i] = '0;
        val_d[i] = '0;
      end
      vld_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
        val_q[i] <= '0;
      end
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= key_d[i];
        val_q[i] <= val_d[i];
      end
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_register_array_pq.sv
// tb/tb_register_array_pq.sv - self-checking bench for register_array_pq
// Scoreboard model holds expected contents; popped heads are compared against it.
module tb_register_array_pq;
  localparam int DEPTH = 8;
  localparam int KW = 16;
  localparam int VW = 16;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic flush, push_valid, pop_ready;
  logic [KW-1:0] push_key;
  logic [VW-1:0] push_val;
  logic push_ready, pop_valid, full, empty, afull;
  logic [KW-1:0] top_key;
  logic [VW-1:0] top_val;
  logic [CW-1:0] count;

  logic n_flush, n_push_valid, n_pop_ready;
  logic [KW-1:0] n_push_key;
  logic [VW-1:0] n_push_val;
  logic n_push_ready, n_pop_valid, n_full, n_empty, n_afull;
  logic [KW-1:0] n_top_key;
  logic [VW-1:0] n_top_val;
  logic [CW-1:0] n_count;

  register_array_pq #(.DEPTH(DEPTH), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_FIRST(1)) dut_max (
    .i_CLK(clk), .i_RSTn(rst_n), .i_flush(flush),
    .i_push_valid(push_valid), .o_push_ready(push_ready),
    .i_push_key(push_key), .i_push_val(push_val),
    .o_pop_valid(pop_valid), .i_pop_ready(pop_ready),
    .o_top_key(top_key), .o_top_val(top_val), .o_count(count),
    .o_full(full), .o_empty(empty), .o_almost_full(afull)
  );

  register_array_pq #(.DEPTH(DEPTH), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_FIRST(0)) dut_min (
    .i_CLK(clk), .i_RSTn(rst_n), .i_flush(n_flush),
    .i_push_valid(n_push_valid), .o_push_ready(n_push_ready),
    .i_push_key(n_push_key), .i_push_val(n_push_val),
    .o_pop_valid(n_pop_valid), .i_pop_ready(n_pop_ready),
    .o_top_key(n_top_key), .o_top_val(n_top_val), .o_count(n_count),
    .o_full(n_full), .o_empty(n_empty), .o_almost_full(n_afull)
  );

  int total = 0;
  int bad = 0;
  logic [KW-1:0] mkey[$];
  logic [VW-1:0] mval[$];

  task automatic model_push(input logic [KW-1:0] k, input logic [VW-1:0] v);
    int j = 0;
    while (j < mkey.size() && mkey[j] >= k) j++;
    mkey.insert(j, k);
    mval.insert(j, v);
  endtask

  // One cycle on dut_max: pushes expectations into the model, pops/compares the head on a pop.
  task automatic sb_cycle(input bit pv, input int k, input int v, input bit pr, input bit fl);
    logic [KW-1:0] ek;
    logic [VW-1:0] ev;
    bit do_pop, do_push;
    push_valid = pv; push_key = KW'(k); push_val = VW'(v); pop_ready = pr; flush = fl;
    #1;
    do_pop  = pr && (mkey.size() > 0);
    do_push = pv && ((mkey.size() < DEPTH) || pr);
    total++;
    if (push_ready !== ((mkey.size() < DEPTH) || pr)) begin
      bad++; $display("FAIL push_ready got=%0b exp=%0b", push_ready, (mkey.size() < DEPTH) || pr);
    end
    if (fl) begin
      mkey.delete(); mval.delete();
    end else begin
      if (do_pop) begin
        ek = mkey.pop_front(); ev = mval.pop_front();
        total++;
        if (top_key !== ek || top_val !== ev) begin
          bad++; $display("FAIL pop_head got=%0d/%0d exp=%0d/%0d", top_key, top_val, ek, ev);
        end
      end
      if (do_push) model_push(KW'(k), VW'(v));
    end
    @(posedge clk); #1;
    push_valid = 0; pop_ready = 0; flush = 0;
    ek = (mkey.size() > 0) ? mkey[0] : '0;
    ev = (mval.size() > 0) ? mval[0] : '0;
    total++;
    if (count !== CW'(mkey.size()) || top_key !== ek || top_val !== ev) begin
      bad++; $display("FAIL state count/key/val got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                      count, top_key, top_val, mkey.size(), ek, ev);
    end
    total++;
    if (empty !== (mkey.size() == 0) || full !== (mkey.size() == DEPTH) ||
        afull !== (mkey.size() >= DEPTH - 1) || pop_valid !== (mkey.size() != 0)) begin
      bad++; $display("FAIL flags e/f/af/pv got=%0b%0b%0b%0b size=%0d", empty, full, afull, pop_valid, mkey.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (count !== 0 || empty !== 1 || full !== 0 || pop_valid !== 0 || push_ready !== 1 ||
        top_key !== 0 || top_val !== 0) begin
      bad++; $display("FAIL reset count=%0d e=%0b f=%0b pv=%0b pr=%0b key=%0d exp 0,1,0,0,1,0",
                      count, empty, full, pop_valid, push_ready, top_key);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int ins[4] = '{5, 9, 1, 7};
    int tops[4] = '{5, 9, 9, 9};
    int outs[4] = '{9, 7, 5, 1};
    for (int i = 0; i < 4; i++) begin
      sb_cycle(1, ins[i], 16 + i, 0, 0);
      total++;
      if (top_key !== KW'(tops[i])) begin
        bad++; $display("FAIL basic_top%0d got=%0d exp=%0d", i, top_key, tops[i]);
      end
    end
    total++;
    if (count !== 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (top_key !== KW'(outs[i])) begin
        bad++; $display("FAIL basic_pop%0d got=%0d exp=%0d", i, top_key, outs[i]);
      end
      sb_cycle(0, 0, 0, 1, 0);
    end
    total++;
    if (empty !== 1 || top_key !== 0) begin
      bad++; $display("FAIL basic_drained e=%0b key=%0d exp 1,0", empty, top_key);
    end
  endtask

  task automatic test_full;
    for (int k = 1; k <= 8; k++) sb_cycle(1, k, 100 + k, 0, 0);
    total++;
    if (full !== 1 || push_ready !== 0) begin
      bad++; $display("FAIL full_flags f=%0b pr=%0b exp 1,0", full, push_ready);
    end
    sb_cycle(1, 30, 130, 0, 0);
    sb_cycle(1, 20, 120, 1, 0);
    total++;
    if (top_key !== 20 || count !== 8) begin
      bad++; $display("FAIL full_replace key=%0d count=%0d exp 20,8", top_key, count);
    end
    for (int i = 0; i < 8; i++) sb_cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_ties;
    int vals[3] = '{'hA, 'hB, 'hC};
    for (int i = 0; i < 3; i++) sb_cycle(1, 3, vals[i], 0, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (top_val !== VW'(vals[i])) begin
        bad++; $display("FAIL tie_order%0d got=%0h exp=%0h", i, top_val, vals[i]);
      end
      sb_cycle(0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_min;
    int ins[3] = '{4, 0, 2};
    int outs[3] = '{0, 2, 4};
    for (int i = 0; i < 3; i++) begin
      n_push_valid = 1; n_push_key = KW'(ins[i]); n_push_val = VW'(i);
      @(posedge clk); #1;
    end
    n_push_valid = 0;
    total++;
    if (n_top_key !== 0 || n_empty !== 0 || n_count !== 3) begin
      bad++; $display("FAIL min_top key=%0d e=%0b count=%0d exp 0,0,3", n_top_key, n_empty, n_count);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (n_top_key !== KW'(outs[i])) begin
        bad++; $display("FAIL min_pop%0d got=%0d exp=%0d", i, n_top_key, outs[i]);
      end
      n_pop_ready = 1;
      @(posedge clk); #1;
      n_pop_ready = 0;
    end
    total++;
    if (n_empty !== 1) begin bad++; $display("FAIL min_empty got=%0b exp=1", n_empty); end
  endtask

  task automatic test_replace;
    sb_cycle(1, 6, 60, 0, 0);
    sb_cycle(1, 2, 20, 1, 0);
    total++;
    if (top_key !== 2 || count !== 1) begin
      bad++; $display("FAIL replace_single key=%0d count=%0d exp 2,1", top_key, count);
    end
    sb_cycle(0, 0, 0, 1, 0);
    sb_cycle(1, 9, 90, 1, 0);
    total++;
    if (top_key !== 9 || count !== 1) begin
      bad++; $display("FAIL pushpop_empty key=%0d count=%0d exp 9,1", top_key, count);
    end
    sb_cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_flush;
    for (int i = 0; i < 5; i++) sb_cycle(1, 10 + i, i, 0, 0);
    sb_cycle(1, 50, 50, 1, 1);
    total++;
    if (count !== 0 || empty !== 1) begin
      bad++; $display("FAIL flush count=%0d e=%0b exp 0,1", count, empty);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) sb_cycle(1, 40 + i, i, 0, 0);
    push_valid = 1; push_key = 77; push_val = 7;
    #2 rst_n = 0;
    #1;
    total++;
    if (count !== 0 || empty !== 1 || top_key !== 0 || top_val !== 0 || pop_valid !== 0) begin
      bad++; $display("FAIL async_reset count=%0d e=%0b key=%0d val=%0d exp 0,1,0,0",
                      count, empty, top_key, top_val);
    end
    mkey.delete(); mval.delete();
    push_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 300; n++)
      sb_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7), n, 1'($urandom_range(0, 1)), 0);
    for (int n = 0; n < DEPTH; n++) sb_cycle(0, 0, 0, 1, 0);
  endtask

  initial begin
    rst_n = 0; flush = 0; push_valid = 0; pop_ready = 0; push_key = 0; push_val = 0;
    n_flush = 0; n_push_valid = 0; n_pop_ready = 0; n_push_key = 0; n_push_val = 0;
    test_reset;
    test_basic;
    test_full;
    test_ties;
    test_min;
    test_replace;
    test_flush;
    test_async_reset;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
